// File: rtl/regwin_exec_ctrl_if.sv
// Instruction handshake and windowed register-file bus between regwin_exec_ctrl
// (master) and its environment: instruction source plus register file (slave).
interface regwin_exec_ctrl_if #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 2,
   parameter int WIN_W   = 2
);
   logic [15:0]        instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [DATA_W-1:0]  data_i;
   logic [DATA_W-1:0]  data_j;
   logic [RADDR_W-1:0] R_i;
   logic [RADDR_W-1:0] R_j;
   logic [WIN_W-1:0]   wnd;
   logic               setWindow;
   logic               toWrite;
   logic [DATA_W-1:0]  write_data;

   modport master (
      input  instr, instr_valid, data_i, data_j,
      output instr_ready, R_i, R_j, wnd, setWindow, toWrite, write_data
   );

   modport slave (
      output instr, instr_valid, data_i, data_j,
      input  instr_ready, R_i, R_j, wnd, setWindow, toWrite, write_data
   );
endinterface

// File: rtl/regwin_exec_ctrl.sv
// Multi-cycle sequencer for the windowed 8x16 register file: accepts one
// instruction, reads operands, runs the ALU, then writes back or switches window.
module regwin_exec_ctrl #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 2,
   parameter int WIN_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   regwin_exec_ctrl_if.master bus,
   output logic [WIN_W-1:0] cur_window,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_READ, ST_EXEC, ST_WRITE, ST_DONE
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_MOVI = 4'd5;
   localparam logic [3:0] OP_WIN  = 4'd6;

   state_t                    state;
   logic [3:0]                op_q;
   logic [7:0]                imm_q;
   logic [RADDR_W-1:0]        ri_q;
   logic [RADDR_W-1:0]        rj_q;
   logic signed [DATA_W-1:0]  op_a;
   logic signed [DATA_W-1:0]  op_b;
   logic [DATA_W-1:0]         result_q;
   logic                      wr_q;
   logic                      sw_q;
   logic [WIN_W-1:0]          wnd_q;

   logic op_writes;
   logic op_win;
   logic op_legal;

   // Arithmetic wraps modulo 2^DATA_W; MOVI zero-extends the immediate.
   function automatic logic [DATA_W-1:0] alu(
      input logic [3:0]               op,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic [7:0]               imm
   );
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_NOT:  return ~b;
         OP_MOVI: return DATA_W'(imm);
         default: return '0;
      endcase
   endfunction

   assign op_writes = (op_q <= OP_MOVI);
   assign op_win    = (op_q == OP_WIN);
   assign op_legal  = ~op_q[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_INIT;
         op_q       <= '0;
         imm_q      <= '0;
         ri_q       <= '0;
         rj_q       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         result_q   <= '0;
         wr_q       <= 1'b0;
         sw_q       <= 1'b0;
         wnd_q      <= '0;
         cur_window <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_INIT: state <= ST_IDLE;
            ST_IDLE: begin
               if (bus.instr_valid) begin
                  op_q  <= bus.instr[15:12];
                  imm_q <= bus.instr[7:0];
                  ri_q  <= RADDR_W'(bus.instr[11:10]);
                  rj_q  <= RADDR_W'(bus.instr[9:8]);
                  err   <= 1'b0;
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               op_a  <= bus.data_i;
               op_b  <= bus.data_j;
               state <= ST_EXEC;
            end
            // Strobes are registered here so they are clean for the whole WRITE cycle.
            ST_EXEC: begin
               if (op_writes) begin
                  result_q <= alu(op_q, op_a, op_b, imm_q);
                  wr_q     <= 1'b1;
               end
               if (op_win) begin
                  sw_q  <= 1'b1;
                  wnd_q <= imm_q[WIN_W-1:0];
               end
               state <= ST_EXEC == state ? ST_WRITE : state;
            end
            ST_WRITE: begin
               wr_q <= 1'b0;
               sw_q <= 1'b0;
               if (op_win) cur_window <= wnd_q;
               done  <= 1'b1;
               err   <= ~op_legal;
               state <= ST_DONE;
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // INIT reloads window 0 in the register file, which rst does not reach.
   assign bus.setWindow   = sw_q | ((state == ST_INIT) & ~rst);
   assign bus.wnd         = wnd_q;
   assign bus.toWrite     = wr_q;
   assign bus.write_data  = result_q;
   assign bus.R_i         = ri_q;
   assign bus.R_j         = rj_q;
   assign bus.instr_ready = (state == ST_IDLE);
   assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_regwin_exec_ctrl.sv
// Bench for regwin_exec_ctrl: windowed register file model, vector table with
// scoreboard queue, plus reset, held-valid and mid-operation reset sequences.
module tb_regwin_exec_ctrl;

   typedef struct {
      logic [15:0] instr;
      logic        wr;
      logic        sw;
      logic [15:0] data;
      logic [1:0]  ri;
      logic [1:0]  wnd;
      logic        err;
      logic [1:0]  cw;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cur_window;
   logic       busy, done, err;

   int checks = 0;
   int errors = 0;
   logic last_err = 1'b0;
   vec_t exp_q[$];
   vec_t tbl[15];

   logic [15:0] rf [8];
   logic [1:0]  rf_win;

   regwin_exec_ctrl_if #(.DATA_W(16), .RADDR_W(2), .WIN_W(2)) bus ();

   regwin_exec_ctrl #(.DATA_W(16), .RADDR_W(2), .WIN_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cur_window (cur_window),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] phys(input logic [1:0] w, input logic [1:0] i);
      return {w, 1'b0} + {1'b0, i};
   endfunction

   // Register file: samples strobes on the falling edge; window not cleared by rst.
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) rf[k] <= 16'h0000;
         rf[2]  <= 16'hFFF0;
         rf_win <= 2'd2;
      end else begin
         if (bus.toWrite)   rf[phys(rf_win, bus.R_i)] <= bus.write_data;
         if (bus.setWindow) rf_win <= bus.wnd;
      end
   end

   assign bus.data_i = rf[phys(rf_win, bus.R_i)];
   assign bus.data_j = rf[phys(rf_win, bus.R_j)];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n, wr_cnt, sw_cnt, both, lat;
      logic [15:0] od;
      logic [1:0]  ori, ownd;
      vec_t e;
      wr_cnt = 0; sw_cnt = 0; both = 0; lat = 0;
      od = '0; ori = '0; ownd = '0;
      @(negedge clk);
      chk($sformatf("v%0d_err_hold", idx), 32'(err), 32'(last_err));
      n = 0;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) begin
         fail_now($sformatf("v%0d_ready", idx));
         return;
      end
      exp_q.push_back(v);
      bus.instr       = v.instr;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.toWrite) begin
            wr_cnt++;
            od  = bus.write_data;
            ori = bus.R_i;
         end
         if (bus.setWindow) begin
            sw_cnt++;
            ownd = bus.wnd;
         end
         if (bus.toWrite && bus.setWindow) both++;
         if (done) begin
            lat = k;
            break;
         end
      end
      e = exp_q.pop_front();
      if (lat == 0) begin
         fail_now($sformatf("v%0d_done", idx));
         return;
      end
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd4);
      chk($sformatf("v%0d_towrite_cnt", idx), 32'(wr_cnt), 32'(e.wr));
      if (e.wr) begin
         chk($sformatf("v%0d_data", idx), 32'(od), 32'(e.data));
         chk($sformatf("v%0d_ri", idx), 32'(ori), 32'(e.ri));
      end
      chk($sformatf("v%0d_setwin_cnt", idx), 32'(sw_cnt), 32'(e.sw));
      if (e.sw) chk($sformatf("v%0d_wnd", idx), 32'(ownd), 32'(e.wnd));
      chk($sformatf("v%0d_both", idx), 32'(both), 32'd0);
      chk($sformatf("v%0d_err", idx), 32'(err), 32'(e.err));
      chk($sformatf("v%0d_cur_window", idx), 32'(cur_window), 32'(e.cw));
      last_err = e.err;
      @(negedge clk);
      chk($sformatf("v%0d_ready_again", idx), 32'(bus.instr_ready), 32'd1);
      chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy, dn, wrs, sws;
      //          instr     wr    sw    data      ri    wnd   err   cw
      tbl[0]  = '{16'h5425, 1'b1, 1'b0, 16'h0025, 2'd1, 2'd0, 1'b0, 2'd0};
      tbl[1]  = '{16'h0900, 1'b1, 1'b0, 16'h0015, 2'd2, 2'd0, 1'b0, 2'd0};
      tbl[2]  = '{16'h1600, 1'b1, 1'b0, 16'h0010, 2'd1, 2'd0, 1'b0, 2'd0};
      tbl[3]  = '{16'h1100, 1'b1, 1'b0, 16'hFFF0, 2'd0, 2'd0, 1'b0, 2'd0};
      tbl[4]  = '{16'h2200, 1'b1, 1'b0, 16'h0010, 2'd0, 2'd0, 1'b0, 2'd0};
      tbl[5]  = '{16'h3E00, 1'b1, 1'b0, 16'h0015, 2'd3, 2'd0, 1'b0, 2'd0};
      tbl[6]  = '{16'h4700, 1'b1, 1'b0, 16'hFFEA, 2'd1, 2'd0, 1'b0, 2'd0};
      tbl[7]  = '{16'h7000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 1'b0, 2'd0};
      tbl[8]  = '{16'hF000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 1'b1, 2'd0};
      tbl[9]  = '{16'h7000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 1'b0, 2'd0};
      tbl[10] = '{16'h8123, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 1'b1, 2'd0};
      tbl[11] = '{16'h6003, 1'b0, 1'b1, 16'h0000, 2'd0, 2'd3, 1'b0, 2'd3};
      tbl[12] = '{16'h5477, 1'b1, 1'b0, 16'h0077, 2'd1, 2'd0, 1'b0, 2'd3};
      tbl[13] = '{16'h0A00, 1'b1, 1'b0, 16'h0020, 2'd2, 2'd0, 1'b0, 2'd3};
      tbl[14] = '{16'h58FF, 1'b1, 1'b0, 16'h00FF, 2'd2, 2'd0, 1'b0, 2'd3};

      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_towrite", 32'(bus.toWrite), 32'd0);
      chk("rst_setwindow", 32'(bus.setWindow), 32'd0);
      chk("rst_cur_window", 32'(cur_window), 32'd0);
      chk("rst_ready", 32'(bus.instr_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("init_setwindow", 32'(bus.setWindow), 32'd1);
      chk("init_wnd", 32'(bus.wnd), 32'd0);
      chk("init_ready", 32'(bus.instr_ready), 32'd0);
      chk("init_towrite", 32'(bus.toWrite), 32'd0);
      @(negedge clk);
      chk("idle_setwindow", 32'(bus.setWindow), 32'd0);
      chk("idle_ready", 32'(bus.instr_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rf_window", 32'(rf_win), 32'd0);

      for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

      // instr_valid held high: one accept per five-cycle transaction.
      bus.instr       = 16'h7000;
      bus.instr_valid = 1'b1;
      rdy = 0; dn = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         rdy += int'(bus.instr_ready);
         dn  += int'(done);
      end
      bus.instr_valid = 1'b0;
      chk("held_valid_accepts", 32'(rdy), 32'd2);
      chk("held_valid_dones", 32'(dn), 32'd2);
      @(negedge clk);
      chk("held_valid_idle", 32'(bus.instr_ready), 32'd1);

      // Reset during EXEC of an ADD: no write, no done, restart at INIT.
      bus.instr       = 16'h0900;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wrs = 0; dn = 0; sws = 0;
      repeat (3) begin
         @(negedge clk);
         wrs += int'(bus.toWrite);
         dn  += int'(done);
         sws += int'(bus.setWindow);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      wrs += int'(bus.toWrite);
      dn  += int'(done);
      chk("midrst_init_setwindow", 32'(bus.setWindow), 32'd1);
      chk("midrst_init_wnd", 32'(bus.wnd), 32'd0);
      @(negedge clk);
      wrs += int'(bus.toWrite);
      dn  += int'(done);
      chk("midrst_no_write", 32'(wrs), 32'd0);
      chk("midrst_no_done", 32'(dn), 32'd0);
      chk("midrst_no_setwin_in_rst", 32'(sws), 32'd0);
      chk("midrst_cur_window", 32'(cur_window), 32'd0);
      chk("midrst_rf_window", 32'(rf_win), 32'd0);
      chk("midrst_ready", 32'(bus.instr_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
